// File: rtl/serial_neg_ctrl.sv
// Bit-serial negation controller: accepts a parallel word, streams it LSB
// first to an external two's-complement datapath, collects the serial result
// and presents the negated word with an overflow flag.
//
// Handshakes: a word transfers on a rising edge where valid && ready are both
// high; valid must not depend on ready, and the offering side holds its data
// stable while valid is high and ready is low.
module serial_neg_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         ser_i,
    output logic         ser_r,
    input  logic         ser_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         busy
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [W-1:0]  shift_reg;
    logic [W-1:0]  result;
    logic          in_msb;
    logic          last_bit;

    // Final serial cycle of a word; the result is complete after this edge.
    assign last_bit = (state == SHIFT) && (count == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/serial-port outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        ser_i     = 1'b0;
        ser_r     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                ser_r    = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                ser_i = shift_reg[0];
                ser_r = (count == '0);
                if (count == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand load, serial shifting, and result capture at the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            shift_reg <= '0;
            result    <= '0;
            in_msb    <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        in_msb    <= in_data[W-1];
                        count     <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    result    <= {ser_y, result[W-1:1]};
                    // Count stops at zero after the last bit rather than wrapping.
                    count     <= last_bit ? '0 : count + CW'(1);
                    if (last_bit) begin
                        // ser_y is the result MSB; only -2^(W-1) keeps its sign.
                        out_data <= {ser_y, result[W-1:1]};
                        out_ovf  <= in_msb & ser_y;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_neg_ctrl.sv
// Directed bench for serial_neg_ctrl with a behavioural serial negator model.
module tb_serial_neg_ctrl;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         ser_i;
    logic         ser_r;
    logic         ser_y;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    serial_neg_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_i     (ser_i),
        .ser_r     (ser_r),
        .ser_y     (ser_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // ---------------- datapath model ----------------
    // Passes bits unchanged up to and including the first 1 after restart,
    // inverts every bit after it.
    logic seen_one;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) seen_one <= 1'b0;
        else if (ser_r) seen_one <= ser_i;
        else seen_one <= seen_one | ser_i;
    end
    assign ser_y = ser_i ^ (seen_one & ~ser_r);

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_ser_r"}, 32'(ser_r), 32'd1);
        check({tag, "_ser_i"}, 32'(ser_i), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_ovf"}, 32'(out_ovf), 32'd0);
    endtask

    // ---------------- driver ----------------
    // Offers one word, measures latency, checks result, holds out_ready low
    // for 'hold' DONE cycles, then completes the output handshake.
    task automatic send_word(input string tag, input logic [W-1:0] data,
                             input logic [W-1:0] exp, input logic exp_ovf,
                             input int hold);
        int cyc;
        int pulses;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        cyc    = 1;
        pulses = 0;
        while (!out_valid && cyc <= 20) begin
            if (ser_r) pulses++;
            if (cyc == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(W + 1));
        check({tag, "_ser_r_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_out_data"}, 32'(out_data), 32'(exp));
        check({tag, "_out_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(out_data), 32'(exp));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_ser_r"}, 32'(ser_r), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_post_data"}, 32'(out_data), 32'(exp));
        check({tag, "_post_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    // ---------------- main sequence ----------------
    initial begin
        int acc_cnt;
        int prev_acc;
        int pulses;
        int guard;

        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // V1..V3
        send_word("v1_05", 8'h05, 8'hFB, 1'b0, 0);
        send_word("v2_00", 8'h00, 8'h00, 1'b0, 0);
        send_word("v2_01", 8'h01, 8'hFF, 1'b0, 0);
        send_word("v3_80", 8'h80, 8'h80, 1'b1, 0);
        send_word("v3_7f", 8'h7F, 8'h81, 1'b0, 0);

        // V4: back-pressure in DONE, then next word right after the handshake
        send_word("v4_a5", 8'hA5, 8'h5B, 1'b0, 5);
        send_word("v4_10", 8'h10, 8'hF0, 1'b0, 0);

        // V5: continuous offer and continuous consume
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'h05;
        out_ready = 1'b1;
        acc_cnt   = 0;
        prev_acc  = -1;
        pulses    = 0;
        for (int i = 0; i < 35; i++) begin
            if (in_valid && in_ready) begin
                if (prev_acc >= 0) check("v5_accept_gap", 32'(i - prev_acc), 32'(W + 2));
                prev_acc = i;
                acc_cnt++;
            end
            if (busy && ser_r) pulses++;
            if (out_valid) check("v5_out_data", 32'(out_data), 32'hFB);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("v5_accepts", 32'(acc_cnt), 32'd4);
        check("v5_ser_r_pulses", 32'(pulses), 32'd4);
        guard = 0;
        while (busy && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check("v5_drain", 32'(busy), 32'd0);
        out_ready = 1'b0;

        // V6: reset in SHIFT cycle 4 aborts the word
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("v6_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("v6_rst");
        @(negedge clk);
        check("v6_rst_held_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        send_word("v6_3c", 8'h3C, 8'hC4, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_neg_ctrl.md
SERIAL_NEG_CTRL -- requirements
Module: serial_neg_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, giving the word width in bits (W >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, the requester's word-offered flag.
REQ-005 SHALL have port in_ready, output, 1, the controller's word-accept flag.
REQ-006 SHALL have port in_data, input, W, the parallel word to negate.
REQ-007 SHALL have port ser_i, output, 1, the serial bit to the two's-complement datapath, LSB first.
REQ-008 SHALL have port ser_r, output, 1, the datapath restart flag, high with the LSB of each word.
REQ-009 SHALL have port ser_y, input, 1, the datapath serial result, valid combinationally in the same cycle as ser_i/ser_r.
REQ-010 SHALL have port out_valid, output, 1, the result-available flag.
REQ-011 SHALL have port out_ready, input, 1, the consumer's accept flag.
REQ-012 SHALL have port out_data, output, W, the negated word.
REQ-013 SHALL have port out_ovf, output, 1, set when the input was -2^(W-1), so the negation overflowed.
REQ-014 SHALL have port busy, output, 1, high in SHIFT or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
- IDLE: in_ready=1, ser_r=1, ser_i=0.
- in_valid=1 -> load shift register and count=0 -> SHIFT.
REQ-016 In SHIFT, each cycle SHALL:
- drive ser_i = shift_reg[0] and ser_r = (count==0);
- shift ser_y into result MSB, shifting result right;
- shift shift_reg right;
- increment count.
REQ-017 SHALL leave SHIFT after exactly W cycles (count==W-1 edge) -> DONE; result holds LSB..MSB of the datapath output aligned to out_data[0..W-1].
REQ-018 In DONE, SHALL set out_valid=1 and hold out_data/out_ovf stable until out_valid && out_ready; then -> IDLE.
REQ-019 Latency SHALL be W+1 cycles from the accept edge to the first cycle of out_valid.
REQ-020 in_ready SHALL be 0 in SHIFT and DONE; in_valid there SHALL be ignored; minimum spacing between accepts SHALL be W+2 cycles.
REQ-021 out_ovf SHALL equal captured input MSB AND result MSB, registered with out_data.
REQ-022 In SHIFT and DONE, ser_r SHALL be 0 except in the first SHIFT cycle; ser_r SHALL never be high for two SHIFT cycles.
REQ-023 out_data SHALL retain the last result after the handshake until the next DONE; out_valid SHALL be 0 outside DONE.
REQ-024 count SHALL be ceil(log2(W)) bits wide and SHALL not wrap within a word.

Reset
REQ-025 While rst_n=0, SHALL force:
- state=IDLE, count=0, shift_reg=0, result=0;
- out_data=0, out_ovf=0, out_valid=0, busy=0;
- in_ready=1, ser_r=1, ser_i=0.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the word with no output; the first edge after deassertion SHALL see IDLE.

Verification
REQ-027 Bench SHALL model the datapath: ser_y = ser_i until the first 1 after ser_r, inverted afterwards (the first 1 itself passes unchanged).
- V1: W=8, in_data=0x05 -> out_data=0xFB, out_ovf=0, out_valid on cycle 9 after accept.
- V2: in_data=0x00 -> 0x00, ovf=0; in_data=0x01 -> 0xFF, ovf=0.
- V3: in_data=0x80 -> 0x80, ovf=1; in_data=0x7F -> 0x81, ovf=0.
- V4: out_ready held 0 for 5 cycles in DONE -> out_valid/out_data stable, in_ready=0; accept on the first high cycle; next word accepted one cycle later.
- V5: in_valid held high continuously -> ser_r pulses exactly once per word at the LSB; accepts exactly W+2 cycles apart.
- V6: rst_n low during SHIFT cycle 4 -> all outputs at reset values immediately; word 0x3C sent afterwards -> 0xC4.
